// File: rtl/fix_shift_sched_if.sv
// rtl/fix_shift_sched_if.sv - requester and result handshake bundle for fix_shift_sched
interface fix_shift_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic [4:0]            out_int;
  logic [15:0]           out_frac;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_tag, out_int, out_frac
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_tag, out_int, out_frac
  );
endinterface

// File: rtl/fix_shift_sched.sv
// rtl/fix_shift_sched.sv - round-robin sharing of one fix_shift unit with tag tracking and 2-deep result FIFO
module fix_shift_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  fix_shift_sched_if.slave   bus,
  output logic [31:0]        fs_data,
  input  logic [4:0]         fs_int,
  input  logic [15:0]        fs_frac,
  output logic               busy
);
  localparam int ENT_W = TAG_W + 21;

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic [TAG_W-1:0] grant;
  logic             grant_vld;
  logic [TAG_W-1:0] rr_next;
  logic [ENT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             pop;
  logic             issue_ok;
  logic [ENT_W-1:0] head;

  // Credit check: the FIFO slots must cover everything buffered plus in flight;
  // a pop in this same cycle frees one slot. Held off entirely while in reset.
  always_comb begin
    pop      = (count != 2'd0) & bus.out_ready;
    issue_ok = rst & (({1'b0, count} + {2'b00, s1_valid}) <= (3'd1 + {2'b00, pop}));
  end

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (issue_ok && !grant_vld && bus.req_valid[idx]) begin
        grant     = TAG_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // One-hot ready, data mux toward fix_shift and the pointer step past the winner.
  always_comb begin
    bus.req_ready = '0;
    fs_data       = 32'd0;
    rr_next       = (int'(grant) == NUM_REQ - 1) ? '0 : grant + TAG_W'(1);
    if (grant_vld) begin
      bus.req_ready[grant] = 1'b1;
      fs_data              = bus.req_data[int'(grant)*32 +: 32];
    end
  end

  // Issue stage: remembers which requester the fix_shift register is working for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      rr_ptr   <= '0;
    end else begin
      s1_valid <= grant_vld;
      if (grant_vld) begin
        s1_tag <= grant;
        rr_ptr <= rr_next;
      end
    end
  end

  // Result FIFO: writes the tagged fix_shift output one cycle after issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (s1_valid) begin
        mem[wr_ptr] <= {s1_tag, fs_int, fs_frac};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({s1_valid, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head of FIFO drives the result port; fields read as zero when empty.
  always_comb begin
    head          = mem[rd_ptr];
    bus.out_valid = (count != 2'd0);
    bus.out_tag   = bus.out_valid ? head[ENT_W-1 -: TAG_W] : '0;
    bus.out_int   = bus.out_valid ? head[20:16] : 5'd0;
    bus.out_frac  = bus.out_valid ? head[15:0] : 16'd0;
    busy          = s1_valid | (count != 2'd0);
  end
endmodule

// File: tb/tb_fix_shift_sched.sv
// tb/tb_fix_shift_sched.sv - self-checking bench for fix_shift_sched with a fix_shift stand-in
module tb_fix_shift_sched;
  logic        clk;
  logic        rst;
  logic [31:0] fs_data;
  logic [4:0]  fs_int;
  logic [15:0] fs_frac;
  logic        busy;
  logic [20:0] fs_q;

  logic [3:0]  rv;
  logic [31:0] rd [4];
  logic        ordy;

  int tests;
  int fails;

  fix_shift_sched_if #(.NUM_REQ(4), .TAG_W(2)) bus ();

  assign bus.req_valid = rv;
  assign bus.req_data  = {rd[3], rd[2], rd[1], rd[0]};
  assign bus.out_ready = ordy;
  assign fs_int        = fs_q[20:16];
  assign fs_frac       = fs_q[15:0];

  fix_shift_sched #(.NUM_REQ(4), .TAG_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fs_data (fs_data),
    .fs_int  (fs_int),
    .fs_frac (fs_frac),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for fix_shift: known words from the test plan, otherwise a simple rearrangement.
  function automatic logic [20:0] fs_fn(input logic [31:0] d);
    if (d == 32'h0000_7000) return {5'd4, 16'h0000};
    if (d == 32'h0000_2001) return {5'd0, 16'h0010};
    return {d[20:16] ^ d[4:0], d[15:0]};
  endfunction

  // Registered like the real unit, sharing clk and rst with the scheduler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fs_q <= '0;
    else      fs_q <= fs_fn(fs_data);
  end

  // Reference model: pointer, in-flight entry and queue of buffered results.
  int          m_rr;
  bit          m_s1;
  logic [22:0] m_s1_ent;
  logic [22:0] m_q [$];
  int          fill_mode;
  bit          ordy_rand;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rv  = 4'hF;
    rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_tag",   64'(bus.out_tag),   64'd0);
    check("rst_out_int",   64'(bus.out_int),   64'd0);
    check("rst_out_frac",  64'(bus.out_frac),  64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_fs_data",   64'(fs_data),       64'd0);
    @(negedge clk);
    m_rr = 0;
    m_s1 = 1'b0;
    m_q.delete();
    rv   = 4'h0;
    rst  = 1'b1;
  endtask

  task automatic cycle();
    logic        exp_ov;
    logic [22:0] hd;
    bit          pop;
    int          g;
    int          idx;
    if (ordy_rand) ordy = 1'($urandom_range(0, 1));
    #1;
    exp_ov = (m_q.size() != 0);
    hd     = exp_ov ? m_q[0] : 23'd0;
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check("out_tag",   64'(bus.out_tag),   64'(hd[22:21]));
    check("out_int",   64'(bus.out_int),   64'(hd[20:16]));
    check("out_frac",  64'(bus.out_frac),  64'(hd[15:0]));
    check("busy",      64'(busy),          64'(m_s1 || exp_ov));
    pop = exp_ov && ordy;
    g   = -1;
    if ((m_q.size() + int'(m_s1)) < 2 + int'(pop)) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_rr + k) % 4;
        if (g < 0 && rv[idx]) g = idx;
      end
    end
    check("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    check("fs_data",   64'(fs_data),       (g >= 0) ? 64'(rd[g]) : 64'd0);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (m_s1) m_q.push_back(m_s1_ent);
    m_s1 = (g >= 0);
    if (g >= 0) begin
      m_s1_ent = {g[1:0], fs_fn(rd[g])};
      m_rr     = (g + 1) % 4;
    end
    @(negedge clk);
    if (g >= 0) begin
      case (fill_mode)
        0: rv[g] = 1'b0;
        1: rd[g] = $urandom;
        default: begin
          rv[g] = 1'($urandom_range(0, 1));
          rd[g] = $urandom;
        end
      endcase
    end
    if (fill_mode == 2) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          rd[i] = $urandom;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    rv        = 4'h0;
    ordy      = 1'b1;
    fill_mode = 0;
    ordy_rand = 1'b0;
    m_rr      = 0;
    m_s1      = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = $urandom;
    @(negedge clk);

    // Reset with all requesters valid, then a single request from requester 0.
    do_reset();
    rd[0] = 32'h0000_7000;
    rv    = 4'b0001;
    run(2);
    check("single0_tag",  64'(bus.out_tag),  64'd0);
    check("single0_int",  64'(bus.out_int),  64'd4);
    check("single0_frac", 64'(bus.out_frac), 64'h0000);
    run(3);

    // Single request from requester 2.
    rd[2] = 32'h0000_2001;
    rv    = 4'b0100;
    run(2);
    check("single2_tag",  64'(bus.out_tag),  64'd2);
    check("single2_int",  64'(bus.out_int),  64'd0);
    check("single2_frac", 64'(bus.out_frac), 64'h0010);
    run(3);

    // All four continuously valid with the consumer always ready.
    do_reset();
    fill_mode = 1;
    rv        = 4'hF;
    run(14);

    // Consumer stalled: two issues fill the FIFO, then drain and resume.
    do_reset();
    rv   = 4'hF;
    ordy = 1'b0;
    run(6);
    ordy = 1'b1;
    run(8);

    // Reset with the FIFO full, then confirm nothing stale comes out.
    ordy = 1'b0;
    run(4);
    do_reset();
    ordy = 1'b1;
    run(4);
    rv = 4'hF;
    run(4);

    // Fairness: requester 0 always valid, requester 2 joins at cycle 3.
    do_reset();
    rv = 4'b0001;
    run(3);
    rv[2] = 1'b1;
    run(10);

    // Randomized traffic and backpressure.
    do_reset();
    fill_mode = 2;
    ordy_rand = 1'b1;
    rv        = 4'($urandom);
    run(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
